// File: rtl/npu_tile_scheduler.sv
// npu_tile_scheduler
//
// Walks an IMG_WIDTH x IMG_HEIGHT frame in TILE_SIZE x TILE_SIZE tiles, in raster order.
// For each tile it:
//   1. reads the pixels from the source RAM into tile_out,
//   2. launches the NPU,
//   3. writes the NPU result back to the RAM at DST_BASE onwards.
// Tiles that stick out past the image edge are padded with zeros. The padded elements are
// never read from the RAM and never written back.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   start, abort     frame request (only taken when idle or done); abandon the frame
//   busy, done       status
//   rd_addr/rd_data  source RAM read port; data arrives RAM_LAT cycles after the address
//   wr_addr/wr_data/wr_en  result write port
//   npu_start        one-cycle pulse that launches the NPU on tile_out
//   npu_done         NPU completion; only looked at in the compute state
//   tile_out         current tile, 16-bit zero-extended elements, r-major
//   npu_result       NPU output, PIX_W-bit elements, same ordering as tile_out
//   tile_count       number of tiles fully written since the last start
module npu_tile_scheduler #(
  parameter int unsigned IMG_WIDTH  = 400,
  parameter int unsigned IMG_HEIGHT = 400,
  parameter int unsigned TILE_SIZE  = 10,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DST_BASE   = IMG_WIDTH * IMG_HEIGHT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  output logic                                   busy,
  output logic                                   done,
  output logic [ADDR_W-1:0]                      rd_addr,
  input  logic [PIX_W-1:0]                       rd_data,
  output logic [ADDR_W-1:0]                      wr_addr,
  output logic [PIX_W-1:0]                       wr_data,
  output logic                                   wr_en,
  output logic                                   npu_start,
  input  logic                                   npu_done,
  output logic [TILE_SIZE*TILE_SIZE*16-1:0]      tile_out,
  input  logic [TILE_SIZE*TILE_SIZE*PIX_W-1:0]   npu_result,
  output logic [15:0]                            tile_count
);

  localparam int unsigned T     = TILE_SIZE;
  localparam int unsigned NX    = (IMG_WIDTH + T - 1) / T;
  localparam int unsigned NY    = (IMG_HEIGHT + T - 1) / T;
  localparam int unsigned CW    = 4;  // row/column counter width (T <= 16)
  localparam int unsigned IDX_W = 8;  // element index width (T*T <= 256)

  // Elaboration-time parameter checks
  if (TILE_SIZE < 2 || TILE_SIZE > 16) begin : g_chk_tile
    $error("TILE_SIZE must be in 2..16");
  end
  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_chk_lat
    $error("RAM_LAT must be in 1..4");
  end
  if (IMG_WIDTH < 1 || IMG_HEIGHT < 1) begin : g_chk_img
    $error("image dimensions must be at least 1");
  end
  if ((longint'(DST_BASE) + longint'(IMG_WIDTH) * longint'(IMG_HEIGHT)) >
      (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("DST_BASE + IMG_WIDTH*IMG_HEIGHT does not fit in ADDR_W bits");
  end

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StCompute,
    StWrite,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           r_q, c_q;
  logic [15:0]             tx_q, ty_q;
  logic [1:0]              drain_q;
  logic                    launched_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic [15:0]             tile_count_q;
  logic [T*T*16-1:0]       tile_q;
  logic [RAM_LAT-1:0]      cap_vld_q;
  logic [IDX_W-1:0]        cap_idx_q [RAM_LAT];

  logic [31:0]             row_idx, col_idx;
  logic                    in_img;
  logic [ADDR_W-1:0]       pix_off;
  logic [IDX_W-1:0]        elem_idx;
  logic                    last_elem, last_tile;
  logic                    go, step_elem, tile_end, issue;

  // Position of the current element within the image
  always_comb begin
    row_idx   = 32'(ty_q) * T + 32'(r_q);
    col_idx   = 32'(tx_q) * T + 32'(c_q);
    in_img    = (col_idx < IMG_WIDTH) && (row_idx < IMG_HEIGHT);
    pix_off   = ADDR_W'(row_idx * IMG_WIDTH + col_idx);
    elem_idx  = IDX_W'(32'(r_q) * T + 32'(c_q));
    last_elem = (r_q == CW'(T - 1)) && (c_q == CW'(T - 1));
    last_tile = (tx_q == 16'(NX - 1)) && (ty_q == 16'(NY - 1));
  end

  always_comb begin
    go        = ((state_q == StIdle) || (state_q == StDone)) && start && !abort;
    step_elem = ((state_q == StRead) || (state_q == StWrite)) && !abort;
    tile_end  = (state_q == StWrite) && !abort && last_elem;
    issue     = (state_q == StRead) && in_img && !abort;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (go) state_d = StRead;
      end
      StRead: begin
        if (abort)          state_d = StIdle;
        else if (last_elem) state_d = StDrain;
      end
      StDrain: begin
        if (abort)                             state_d = StIdle;
        else if (drain_q == 2'(RAM_LAT - 1))   state_d = StCompute;
      end
      StCompute: begin
        if (abort)         state_d = StIdle;
        else if (npu_done) state_d = StWrite;
      end
      StWrite: begin
        if (abort)          state_d = StIdle;
        else if (last_elem) state_d = last_tile ? StDone : StRead;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != StIdle) && (state_q != StDone);
    done      = (state_q == StDone);
    // Padded elements issue no new address, so the port keeps its last value.
    rd_addr   = ((state_q == StRead) && in_img) ? pix_off : rd_addr_q;
    npu_start = (state_q == StCompute) && !launched_q && !abort;
    wr_en     = (state_q == StWrite) && in_img && !abort;
    wr_addr   = '0;
    wr_data   = '0;
    if (state_q == StWrite) begin
      wr_addr = ADDR_W'(DST_BASE) + pix_off;
      wr_data = npu_result[PIX_W*elem_idx +: PIX_W];
    end
    tile_out   = tile_q;
    tile_count = tile_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, tile buffer and read-capture pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q          <= '0;
      c_q          <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      drain_q      <= '0;
      launched_q   <= 1'b0;
      rd_addr_q    <= '0;
      tile_count_q <= '0;
      tile_q       <= '0;
      cap_vld_q    <= '0;
      for (int i = 0; i < RAM_LAT; i++) cap_idx_q[i] <= '0;
    end else begin
      rd_addr_q  <= rd_addr;
      // Set only after the first compute cycle, so npu_start is a single pulse.
      launched_q <= (state_q == StCompute);
      drain_q    <= ((state_q == StDrain) && !abort) ? drain_q + 2'd1 : 2'd0;

      if (go) begin
        r_q          <= '0;
        c_q          <= '0;
        tx_q         <= '0;
        ty_q         <= '0;
        tile_count_q <= '0;
      end else begin
        if (step_elem) begin
          if (c_q == CW'(T - 1)) begin
            c_q <= '0;
            r_q <= (r_q == CW'(T - 1)) ? '0 : r_q + 1'b1;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        if (tile_end) begin
          tile_count_q <= tile_count_q + 16'd1;
          if (!last_tile) begin
            if (tx_q == 16'(NX - 1)) begin
              tx_q <= '0;
              ty_q <= ty_q + 16'd1;
            end else begin
              tx_q <= tx_q + 16'd1;
            end
          end
        end
      end

      // Each stage carries (valid, element index). The last stage lines up with rd_data.
      if (abort) begin
        cap_vld_q <= '0;
      end else begin
        cap_vld_q[0] <= issue;
        for (int i = 1; i < RAM_LAT; i++) cap_vld_q[i] <= cap_vld_q[i-1];
      end
      cap_idx_q[0] <= elem_idx;
      for (int i = 1; i < RAM_LAT; i++) cap_idx_q[i] <= cap_idx_q[i-1];

      if ((state_q == StRead) && !in_img && !abort) begin
        tile_q[16*elem_idx +: 16] <= 16'd0;
      end
      if (cap_vld_q[RAM_LAT-1]) begin
        tile_q[16*cap_idx_q[RAM_LAT-1] +: 16] <= 16'(rd_data);
      end
    end
  end

endmodule

// File: tb/tb_npu_tile_scheduler.sv
// Bench for npu_tile_scheduler. It drives three instances:
//   A: 4x4 image, T=2, RAM_LAT=1, pixel = address
//   B: 5x3 image, T=2, RAM_LAT=2, pixel = address + 1
//   C: 400x400 image, T=10, RAM_LAT=3, pixel = address
module tb_npu_tile_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int r;
    int c;
    int addr;
  } tvec_t;

  // ---------------- Instance A ----------------
  logic        start_a = 1'b0, abort_a = 1'b0, force_done_a = 1'b0;
  logic        busy_a, done_a, wr_en_a, npu_start_a, npu_done_a;
  logic [5:0]  rd_addr_a, wr_addr_a;
  logic [7:0]  rd_data_a, wr_data_a;
  logic [63:0] tile_out_a;
  logic [31:0] npu_result_a;
  logic [15:0] tile_count_a;
  int          cnt_a = 0;
  int          wr_cnt_a = 0;
  int          nst_cnt_a = 0;
  wr_t         exp_wr_a [$];

  npu_tile_scheduler #(
    .IMG_WIDTH(4), .IMG_HEIGHT(4), .TILE_SIZE(2), .PIX_W(8), .RAM_LAT(1), .ADDR_W(6),
    .DST_BASE(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .wr_en(wr_en_a), .npu_start(npu_start_a), .npu_done(npu_done_a), .tile_out(tile_out_a),
    .npu_result(npu_result_a), .tile_count(tile_count_a)
  );

  always @(posedge clk) rd_data_a <= 8'(rd_addr_a);
  always @(posedge clk) begin
    if (npu_start_a)    cnt_a <= 3;
    else if (cnt_a > 0) cnt_a <= cnt_a - 1;
  end
  assign npu_done_a = (cnt_a == 1) || force_done_a;
  always_comb begin
    npu_result_a = '0;
    for (int e = 0; e < 4; e++) npu_result_a[8*e +: 8] = tile_out_a[16*e +: 8];
  end

  // ---------------- Instance B ----------------
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic        busy_b, done_b, wr_en_b, npu_start_b, npu_done_b;
  logic [5:0]  rd_addr_b, wr_addr_b;
  logic [7:0]  rd_data_b, wr_data_b, pb0, pb1;
  logic [63:0] tile_out_b;
  logic [31:0] npu_result_b;
  logic [15:0] tile_count_b;
  int          cnt_b = 0;
  int          wr_cnt_b = 0;
  wr_t         exp_wr_b [$];
  logic [63:0] exp_tile_b [$];

  npu_tile_scheduler #(
    .IMG_WIDTH(5), .IMG_HEIGHT(3), .TILE_SIZE(2), .PIX_W(8), .RAM_LAT(2), .ADDR_W(6),
    .DST_BASE(15)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_en(wr_en_b), .npu_start(npu_start_b), .npu_done(npu_done_b), .tile_out(tile_out_b),
    .npu_result(npu_result_b), .tile_count(tile_count_b)
  );

  always @(posedge clk) begin
    pb0 <= 8'(rd_addr_b + 1);
    pb1 <= pb0;
  end
  assign rd_data_b = pb1;
  always @(posedge clk) begin
    if (npu_start_b)    cnt_b <= 3;
    else if (cnt_b > 0) cnt_b <= cnt_b - 1;
  end
  assign npu_done_b = (cnt_b == 1);
  always_comb begin
    npu_result_b = '0;
    for (int e = 0; e < 4; e++) npu_result_b[8*e +: 8] = tile_out_b[16*e +: 8];
  end

  // ---------------- Instance C ----------------
  logic          start_c = 1'b0, abort_c = 1'b0;
  logic          busy_c, done_c, wr_en_c, npu_start_c;
  logic [18:0]   rd_addr_c, wr_addr_c;
  logic [7:0]    rd_data_c, wr_data_c, pc0, pc1, pc2;
  logic [1599:0] tile_out_c;
  logic [799:0]  npu_result_c = '0;
  logic          npu_done_c = 1'b0;
  logic [15:0]   tile_count_c;

  npu_tile_scheduler #(
    .IMG_WIDTH(400), .IMG_HEIGHT(400), .TILE_SIZE(10), .PIX_W(8), .RAM_LAT(3), .ADDR_W(19)
  ) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .busy(busy_c), .done(done_c),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .wr_en(wr_en_c), .npu_start(npu_start_c), .npu_done(npu_done_c), .tile_out(tile_out_c),
    .npu_result(npu_result_c), .tile_count(tile_count_c)
  );

  always @(posedge clk) begin
    pc0 <= 8'(rd_addr_c);
    pc1 <= pc0;
    pc2 <= pc1;
  end
  assign rd_data_c = pc2;

  // ---------------- Scoreboard monitors ----------------
  always @(negedge clk) begin
    wr_t ew;
    if (npu_start_a) nst_cnt_a++;
    if (wr_en_a) begin
      wr_cnt_a++;
      if (exp_wr_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_write: got addr %0d, required no write", wr_addr_a);
      end else begin
        ew = exp_wr_a.pop_front();
        check("a_wr_addr", 64'(wr_addr_a), 64'(ew.addr));
        check("a_wr_data", 64'(wr_data_a), 64'(ew.data));
      end
    end
    if (wr_en_b) begin
      wr_cnt_b++;
      if (exp_wr_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_write: got addr %0d, required no write", wr_addr_b);
      end else begin
        ew = exp_wr_b.pop_front();
        check("b_wr_addr", 64'(wr_addr_b), 64'(ew.addr));
        check("b_wr_data", 64'(wr_data_b), 64'(ew.data));
      end
    end
    if (npu_start_b) begin
      if (exp_tile_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_npu_start: got pulse, required none");
      end else begin
        check("b_tile_out", tile_out_b, exp_tile_b.pop_front());
      end
    end
  end

  // ---------------- Expectation builders ----------------
  task automatic push_a();
    for (int ty = 0; ty < 2; ty++)
      for (int tx = 0; tx < 2; tx++)
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) begin
            int a;
            a = (ty*2 + r) * 4 + (tx*2 + c);
            exp_wr_a.push_back('{addr: 8'(16 + a), data: 8'(a)});
          end
  endtask

  task automatic push_b();
    for (int ty = 0; ty < 2; ty++)
      for (int tx = 0; tx < 3; tx++) begin
        logic [63:0] t;
        t = '0;
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) begin
            int row, col;
            row = ty*2 + r;
            col = tx*2 + c;
            if (row < 3 && col < 5) begin
              t[16*(r*2 + c) +: 16] = 16'(row*5 + col + 1);
              exp_wr_b.push_back('{addr: 8'(15 + row*5 + col), data: 8'(row*5 + col + 1)});
            end
          end
        exp_tile_b.push_back(t);
      end
  endtask

  // Runs one frame on A from a negedge. With inject set, a start pulse lands during WRITE.
  task automatic run_a(input bit inject, output int cyc);
    int  n;
    bit  injected;
    n = 0;
    injected = 1'b0;
    push_a();
    start_a = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      n++;
      start_a = 1'b0;
      if (n == 1) check("a_first_rd_addr", 64'(rd_addr_a), 64'd0);
      if (inject && !injected && wr_en_a) begin
        start_a  = 1'b1;
        injected = 1'b1;
      end
      if (done_a) break;
    end
    cyc = n - 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tvec_t tv [5];
    int    n, k, cyc, w0, s0;

    tv[0] = '{r: 0, c: 0, addr: 0};
    tv[1] = '{r: 0, c: 9, addr: 9};
    tv[2] = '{r: 1, c: 0, addr: 400};
    tv[3] = '{r: 5, c: 3, addr: 2003};
    tv[4] = '{r: 9, c: 9, addr: 3609};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_rd_addr", 64'(rd_addr_a), 64'd0);
    check("rst_wr_addr", 64'(wr_addr_a), 64'd0);
    check("rst_wr_data", 64'(wr_data_a), 64'd0);
    check("rst_wr_en", 64'(wr_en_a), 64'd0);
    check("rst_npu_start", 64'(npu_start_a), 64'd0);
    check("rst_tile_count", 64'(tile_count_a), 64'd0);
    check("rst_tile_out", tile_out_a, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // C: 400x400, RAM_LAT=3, tile 0 contents at its first COMPUTE cycle
    start_c = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      start_c = 1'b0;
      if (npu_start_c) break;
    end
    check("c_cycles_to_compute", 64'(n - 1), 64'd103);
    for (int i = 0; i < 5; i++) begin
      check("c_tile_elem", 64'(tile_out_c[16*(tv[i].r*10 + tv[i].c) +: 16]),
            64'(tv[i].addr % 256));
    end
    abort_c = 1'b1;
    @(negedge clk);
    abort_c = 1'b0;
    check("c_abort_idle", 64'(busy_c), 64'd0);

    // B: 5x3 image with padded tiles
    push_b();
    start_b = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      start_b = 1'b0;
      if (done_b) break;
    end
    check("b_frame_cycles", 64'(n - 1), 64'd84);
    check("b_tile_count", 64'(tile_count_b), 64'd6);
    check("b_write_count", 64'(wr_cnt_b), 64'd15);
    check("b_writes_left", 64'(exp_wr_b.size()), 64'd0);
    check("b_tiles_left", 64'(exp_tile_b.size()), 64'd0);

    // A: full frame
    run_a(1'b0, cyc);
    check("a_frame_cycles", 64'(cyc), 64'd52);
    check("a_tile_count", 64'(tile_count_a), 64'd4);
    check("a_done", 64'(done_a), 64'd1);
    check("a_busy_at_done", 64'(busy_a), 64'd0);
    check("a_writes_left", 64'(exp_wr_a.size()), 64'd0);

    // A: start pulse while in WRITE is ignored
    run_a(1'b1, cyc);
    check("a_inject_cycles", 64'(cyc), 64'd52);
    check("a_inject_tile_count", 64'(tile_count_a), 64'd4);
    check("a_inject_writes_left", 64'(exp_wr_a.size()), 64'd0);

    // A: abort on the first COMPUTE cycle of tile 2
    push_a();
    start_a = 1'b1;
    n = 0;
    k = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      start_a = 1'b0;
      if (npu_start_a) k++;
      if (k == 3) break;
    end
    abort_a = 1'b1;
    #1;
    check("a_abort_npu_start_gated", 64'(npu_start_a), 64'd0);
    @(negedge clk);
    abort_a = 1'b0;
    check("a_abort_busy", 64'(busy_a), 64'd0);
    check("a_abort_tile_count", 64'(tile_count_a), 64'd2);
    check("a_abort_writes_left", 64'(exp_wr_a.size()), 64'd8);
    exp_wr_a.delete();
    w0 = wr_cnt_a;
    s0 = nst_cnt_a;
    repeat (30) @(negedge clk);
    check("a_abort_no_writes", 64'(wr_cnt_a), 64'(w0));
    check("a_abort_no_npu_start", 64'(nst_cnt_a), 64'(s0));

    // A: restart after abort begins again at tile 0
    run_a(1'b0, cyc);
    check("a_restart_cycles", 64'(cyc), 64'd52);
    check("a_restart_tile_count", 64'(tile_count_a), 64'd4);
    check("a_restart_writes_left", 64'(exp_wr_a.size()), 64'd0);

    // A: abort during WRITE gates wr_en in that cycle
    push_a();
    start_a = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      start_a = 1'b0;
      if (wr_en_a) break;
    end
    abort_a = 1'b1;
    #1;
    check("a_abort_wr_en_gated", 64'(wr_en_a), 64'd0);
    @(negedge clk);
    abort_a = 1'b0;
    check("a_abort_write_busy", 64'(busy_a), 64'd0);
    check("a_abort_write_tile_count", 64'(tile_count_a), 64'd0);
    exp_wr_a.delete();

    // A: reset during WRITE of tile 1
    push_a();
    start_a = 1'b1;
    n = 0;
    k = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      start_a = 1'b0;
      if (wr_en_a) k++;
      if (k == 5) break;
    end
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_done", 64'(done_a), 64'd0);
    check("mid_rst_wr_en", 64'(wr_en_a), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr_a), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data_a), 64'd0);
    check("mid_rst_rd_addr", 64'(rd_addr_a), 64'd0);
    check("mid_rst_npu_start", 64'(npu_start_a), 64'd0);
    check("mid_rst_tile_count", 64'(tile_count_a), 64'd0);
    check("mid_rst_tile_out", tile_out_a, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_wr_a.delete();
    w0 = wr_cnt_a;
    force_done_a = 1'b1;
    @(negedge clk);
    force_done_a = 1'b0;
    check("idle_npu_done_busy", 64'(busy_a), 64'd0);
    check("idle_npu_done_done", 64'(done_a), 64'd0);
    repeat (20) @(negedge clk);
    check("post_rst_no_writes", 64'(wr_cnt_a), 64'(w0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
